// File: rtl/md_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | md_issue_ctrl: mult/div issue gating, HI/LO hazard stall, stall counter   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module md_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       d_md_class,
  input  logic             e_valid,
  input  logic [3:0]       e_md_op,
  input  logic             e_flush,
  input  logic             md_busy,
  output logic             md_start,
  output logic [3:0]       md_op,
  output logic             stall_d,
  output logic             proto_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [3:0] OP_NOP  = 4'b1111;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] cnt_nxt;
  logic             e_live;
  logic             start_op;
  logic             hilo_write;
  logic             viol;

  assign e_live     = e_valid & ~e_flush;
  assign start_op   = (e_md_op < 4'd4);
  assign hilo_write = (e_md_op == 4'd4) | (e_md_op == 4'd5);
  assign viol       = e_live & (start_op | hilo_write) & (state != S_IDLE);

  // State register plus the sticky error flag and saturating stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      proto_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (viol) begin
        proto_err <= 1'b1;
      end
      if (stall_d && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (md_start) begin
          state_nxt = S_BUSY;
          cnt_nxt   = e_md_op[1] ? LAT_W'(DIV_LAT) : LAT_W'(MUL_LAT);
        end
      end
      S_BUSY: begin
        // <= 1 also keeps a zero latency setting from wrapping the counter
        if (cnt <= LAT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = md_busy ? S_DRAIN : S_IDLE;
        end else begin
          cnt_nxt = cnt - LAT_W'(1);
        end
      end
      S_DRAIN: begin
        if (!md_busy) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of the flops
  always_comb begin
    md_start = 1'b0;
    md_op    = OP_NOP;
    stall_d  = 1'b0;
    if (reset) begin
      md_start = (state == S_IDLE) & e_live & start_op & ~md_busy;
      md_op    = e_live ? e_md_op : OP_NOP;
      stall_d  = (d_md_class != 2'd0) & ((state != S_IDLE) | md_busy | md_start);
    end
  end

endmodule
`default_nettype wire

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue and hazard controller placed between the D/E pipeline stages and the multiply/divide unit. It decides when an E-stage mult/multu/div/divu may start, forwards the op code and start pulse, and stalls D-stage HI/LO instructions while the unit is occupied. It also suppresses starts on an exception flush and flags protocol violations. It tracks unit latency with its own counter, and uses the unit's `Busy` as a backstop.

## Interface
Parameters:
- `MUL_LAT`, 5: occupied cycles after a mult/multu start cycle.
- `DIV_LAT`, 10: occupied cycles after a div/divu start cycle.
- `CNT_W`, 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `d_md_class`  in  2  D-stage instruction class: 0 none, 1 start op, 2 mfhi/mflo, 3 mthi/mtlo.
- `e_valid`  in  1  the E-stage instruction is valid.
- `e_md_op`  in  4  E-stage op code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, others no-op.
- `e_flush`  in  1  an exception or interrupt is flushing E this cycle.
- `md_busy`  in  1  the `Busy` signal from the multiply/divide unit.
- `md_start`  out  1  start pulse to the unit (combinational).
- `md_op`  out  4  op code to the unit (combinational).
- `stall_d`  out  1  hold the D stage this cycle (combinational).
- `proto_err`  out  1  sticky protocol-violation flag.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `stall_d`=1.

## Operation
- States:
  - IDLE: the unit is free.
  - BUSY: the latency counter is running.
  - DRAIN: the counter has expired but `md_busy` is still 1.
- Start ops are `e_md_op` values 0–3.
- `md_start` = (state==IDLE) & `e_valid` & start op & !`e_flush` & !`md_busy`.
- `md_op`:
  - equals `e_md_op` when `e_valid` & !`e_flush`;
  - otherwise 4'b1111, the no-op code, so a flushed mthi/mtlo cannot write.
- IDLE → BUSY when `md_start`=1. `cnt` loads `MUL_LAT` for ops 0/1 and `DIV_LAT` for ops 2/3.
- In BUSY, `cnt` decrements every cycle. At `cnt`==1:
  - `md_busy`=0 → IDLE;
  - `md_busy`=1 → DRAIN.
- DRAIN → IDLE on the first cycle with `md_busy`=0.
- Occupied = (state!=IDLE) | `md_busy` | `md_start`.
- `stall_d` = (`d_md_class`!=0) & occupied.
  - All three HI/LO classes stall, so mfhi/mflo never read stale HI/LO.
  - mthi/mtlo never overwrite an in-flight result.
- `proto_err` is set, and stays set until reset, when `e_valid` & start op or op 4/5 & !`e_flush` occurs while state!=IDLE. No start is issued in that case.
- `stall_cnt` increments on each cycle with `stall_d`=1 and saturates at all-ones.
- Reset, including in the middle of an operation:
  - state=IDLE, `cnt`=0, `proto_err`=0, `stall_cnt`=0;
  - while `reset`=0, `md_start`=0, `stall_d`=0, and `md_op`=4'b1111.
- After reset releases, `md_busy` still gates starts and stalls. A unit that is still busy is therefore waited out.

## Timing
- A start issued in cycle 0 makes the unit busy from the following rising edge.
- mult/multu:
  - the state is BUSY in cycles 1–5 and IDLE in cycle 6;
  - an mfhi/mflo held in D during cycles 0–5 enters E in cycle 6 and reads the new HI/LO.
- div/divu: BUSY in cycles 1–10, IDLE in cycle 11.
- A back-to-back start is accepted at the earliest in cycle 6 for mult and cycle 11 for div.
- `e_flush` and a start op in the same cycle: the flush wins, with no start and no state change.
- mthi/mtlo in E while IDLE: `md_start`=0, `md_op` is passed through, and the unit writes on that same edge.
- `stall_d` has zero-cycle latency from `d_md_class`.

## Test plan
- Reset=0 → 1, then `e_valid`=1, op 0 in cycle 0, `d_md_class`=2 held → `md_start`=1 only in cycle 0; `stall_d`=1 in cycles 0–5 and 0 in cycle 6; `stall_cnt`=6.
- Op 2 in cycle 0, `d_md_class`=1 → `stall_d`=1 in cycles 0–10; state returns to IDLE in cycle 11; `md_op`=2 in cycle 0.
- `e_flush`=1 together with op 3 → `md_start`=0, `md_op`=4'b1111, state stays IDLE, `stall_d`=0 for `d_md_class`=2.
- Op 0 start with `md_busy` held 1 until cycle 8 → the state reaches DRAIN in cycle 6 and IDLE in cycle 9; `stall_d` is 1 through cycle 8.
- Op 1 start, then `e_valid`=1 op 0 in cycle 3 → `md_start`=0 in cycle 3; `proto_err`=1 from cycle 4 and stays 1 until reset.
- `reset`=0 asserted in cycle 4 of a div → state=IDLE and `proto_err`=0 immediately; `stall_cnt`=0.
- Separately, `d_md_class`=2 with `md_busy`=1 for 70000 cycles → `stall_cnt` saturates at 16'hFFFF.
